bc_rx_ahbl_word_writer: RTL and testbench

//  AHB-Lite master that feeds the BC RX AHB-Lite SRAM controller. Takes decoded 1553 RX words
//  (16-bit + end-of-message flag) over valid/ready, buffers them, and writes each one as a

---
 rtl/bc_rx_wr_pkg.sv | 34 +++
 rtl/bc_rx_word_fifo.sv | 69 ++++++
 rtl/bc_rx_ahbl_word_writer.sv | 194 +++++++++++++++++++
 tb/tb_bc_rx_ahbl_word_writer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_rx_wr_pkg.sv
// ============================================================================
// bc_rx_wr_pkg : shared AHB-Lite constants, FSM state and FIFO entry types
//                for the BC RX word writer.
// Revision     : 1.0
// ============================================================================
`default_nettype none

package bc_rx_wr_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } fsm_state_t;

  typedef struct packed {
    logic        eom;
    logic [15:0] data;
  } fifo_entry_t;

  // Byte address of a halfword slot in the ring.
  function automatic logic [31:0] ring_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + (idx << 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bc_rx_word_fifo.sv
// ============================================================================
// bc_rx_word_fifo : synchronous FIFO of DEPTH x 17-bit RX word entries with
//                   full/empty flags; synchronous active-low reset.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module bc_rx_word_fifo
  import bc_rx_wr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  fifo_entry_t data_i,
  input  logic        pop_i,
  output fifo_entry_t data_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          w_do_push;
  logic          w_do_pop;

  // Guards keep the pointers coherent even if a caller misbehaves.
  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_do_push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (w_do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/bc_rx_ahbl_word_writer.sv
// ============================================================================
// bc_rx_ahbl_word_writer : AHB-Lite master writing buffered 1553 RX words as
//                          SINGLE halfword writes into an SRAM ring buffer.
// Option                 : BC_RX_WR_ERR_CNT_EN adds the err_cnt[7:0] output.
// Revision               : 1.0
// ============================================================================
`default_nettype none

module bc_rx_ahbl_word_writer
  import bc_rx_wr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          RING_WORDS = 1024,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          HCLK,
  input  logic                          HRESETN,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [15:0]                   in_data,
  input  logic                          in_eom,
  input  logic                          ptr_clr,
  output logic [31:0]                   HADDR,
  output logic [1:0]                    HTRANS,
  output logic                          HWRITE,
  output logic [2:0]                    HSIZE,
  output logic [2:0]                    HBURST,
  output logic [31:0]                   HWDATA,
  input  logic                          HREADY,
  input  logic [1:0]                    HRESP,
  output logic [$clog2(RING_WORDS)-1:0] wr_ptr,
  output logic                          msg_done,
  output logic                          wr_err,
  output logic                          busy
`ifdef BC_RX_WR_ERR_CNT_EN
  ,
  output logic [7:0]                    err_cnt
`endif
);

  localparam int PTR_W = $clog2(RING_WORDS);

  fsm_state_t  state_q;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic        clr_pend_q;
  logic [31:0] haddr_q;
  logic [1:0]  htrans_q;
  logic [31:0] hwdata_q;
  logic        eom_q;
  logic        msg_done_q;
  logic        wr_err_q;
  logic        rdy_en_q;

  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  fifo_entry_t w_in_entry;
  fifo_entry_t w_head;
  logic        w_done;
  logic        w_err_evt;
  logic        w_unused_hresp;

  assign w_unused_hresp = HRESP[1];

  assign w_in_entry = '{eom: in_eom, data: in_data};
  assign w_push     = in_valid & in_ready;
  assign w_pop      = (state_q == ADDR) & HREADY;
  assign w_done     = (state_q == DATA) & HREADY;
  assign w_err_evt  = w_done & HRESP[0];

  bc_rx_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_ni  (HRESETN),
    .push_i  (w_push),
    .data_i  (w_in_entry),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // A clear seen while a transfer is in flight replaces the next increment.
  always_comb begin
    ptr_d = ptr_q;
    if ((state_q == IDLE) && ptr_clr) begin
      ptr_d = '0;
    end else if (w_done) begin
      if (clr_pend_q || ptr_clr || (ptr_q == PTR_W'(RING_WORDS - 1))) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      clr_pend_q <= 1'b0;
      haddr_q    <= BASE_ADDR;
      htrans_q   <= HTRANS_IDLE;
      hwdata_q   <= '0;
      eom_q      <= 1'b0;
      msg_done_q <= 1'b0;
      wr_err_q   <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      rdy_en_q   <= 1'b1;
      ptr_q      <= ptr_d;
      msg_done_q <= 1'b0;
      wr_err_q   <= 1'b0;

      if (w_done) begin
        clr_pend_q <= 1'b0;
      end else if (ptr_clr && (state_q != IDLE)) begin
        clr_pend_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (!w_empty) begin
            state_q  <= ADDR;
            htrans_q <= HTRANS_NONSEQ;
            haddr_q  <= ring_addr(BASE_ADDR, 32'(ptr_d));
          end
        end
        ADDR: begin
          if (HREADY) begin
            state_q  <= DATA;
            htrans_q <= HTRANS_IDLE;
            hwdata_q <= {w_head.data, w_head.data};
            eom_q    <= w_head.eom;
          end
        end
        DATA: begin
          if (HREADY) begin
            msg_done_q <= eom_q;
            wr_err_q   <= HRESP[0];
            if (!w_empty) begin
              state_q  <= ADDR;
              htrans_q <= HTRANS_NONSEQ;
              haddr_q  <= ring_addr(BASE_ADDR, 32'(ptr_d));
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          htrans_q <= HTRANS_IDLE;
        end
      endcase
    end
  end

`ifdef BC_RX_WR_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      err_cnt_q <= '0;
    end else if (ptr_clr) begin
      err_cnt_q <= '0;
    end else if (w_err_evt && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic w_unused_err_evt;
  assign w_unused_err_evt = w_err_evt;
`endif

  assign in_ready = rdy_en_q & ~w_full;
  assign HADDR    = haddr_q;
  assign HTRANS   = htrans_q;
  assign HWRITE   = 1'b1;
  assign HSIZE    = HSIZE_HALF;
  assign HBURST   = HBURST_SINGLE;
  assign HWDATA   = hwdata_q;
  assign wr_ptr   = ptr_q;
  assign msg_done = msg_done_q;
  assign wr_err   = wr_err_q;
  assign busy     = (state_q != IDLE) | ~w_empty;

endmodule

`default_nettype wire

// File: tb/tb_bc_rx_ahbl_word_writer.sv
// ============================================================================
// tb_bc_rx_ahbl_word_writer : directed self-checking bench for the RX word
//                             writer (RING_WORDS=8, FIFO_DEPTH=4).
// Revision                  : 1.0
// ============================================================================
`default_nettype none

module tb_bc_rx_ahbl_word_writer;

  localparam logic [31:0] BASE = 32'h2000_0100;
  localparam int          RW   = 8;
  localparam int          FD   = 4;

  logic        HCLK     = 1'b0;
  logic        HRESETN  = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data  = '0;
  logic        in_eom   = 1'b0;
  logic        ptr_clr  = 1'b0;
  logic        HREADY   = 1'b1;
  logic [1:0]  HRESP    = 2'b00;
  logic        in_ready;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [2:0]  wr_ptr;
  logic        msg_done;
  logic        wr_err;
  logic        busy;
`ifdef BC_RX_WR_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int n_msg  = 0;
  int n_err  = 0;
  logic dph  = 1'b0;
  logic [31:0] mon_addr[$];
  logic [31:0] mon_data[$];
  int base_idx;
  int msg0;
  int err0;

  bc_rx_ahbl_word_writer #(
    .BASE_ADDR  (BASE),
    .RING_WORDS (RW),
    .FIFO_DEPTH (FD)
  ) dut (
`ifdef BC_RX_WR_ERR_CNT_EN
    .err_cnt  (err_cnt),
`endif
    .HCLK     (HCLK),
    .HRESETN  (HRESETN),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_eom   (in_eom),
    .ptr_clr  (ptr_clr),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HBURST   (HBURST),
    .HWDATA   (HWDATA),
    .HREADY   (HREADY),
    .HRESP    (HRESP),
    .wr_ptr   (wr_ptr),
    .msg_done (msg_done),
    .wr_err   (wr_err),
    .busy     (busy)
  );

  always #5 HCLK = ~HCLK;

  // Bus monitor: logs every accepted address and every completed data phase.
  always @(negedge HCLK) begin
    if (HRESETN) begin
      if (msg_done) n_msg <= n_msg + 1;
      if (wr_err)   n_err <= n_err + 1;
      if (dph && HREADY) begin
        mon_data.push_back(HWDATA);
        dph <= 1'b0;
      end else if (HTRANS == 2'b10 && HREADY) begin
        mon_addr.push_back(HADDR);
        dph <= 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic e);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_eom   = e;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("push_timeout", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_eom   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("drain_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    // Reset
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_htrans",   HTRANS,   0);
    chk("rst_haddr",    HADDR,    BASE);
    chk("rst_hwdata",   HWDATA,   0);
    chk("rst_wr_ptr",   wr_ptr,   0);
    chk("rst_busy",     busy,     0);
    chk("rst_msg_done", msg_done, 0);
    chk("rst_wr_err",   wr_err,   0);
`ifdef BC_RX_WR_ERR_CNT_EN
    chk("rst_err_cnt",  err_cnt,  0);
`endif
    HRESETN = 1'b1;
    tick();
    chk("in_ready_after_rst", in_ready, 1);
    chk("hwrite", HWRITE, 1);
    chk("hsize",  HSIZE,  3'b001);
    chk("hburst", HBURST, 3'b000);

    // 1: zero-wait slave, three words, eom on the last
    msg0 = n_msg;
    in_valid = 1'b1; in_data = 16'hA001; in_eom = 1'b0;
    tick();
    chk("s1_idle_after_push", HTRANS, 2'b00);
    chk("s1_busy", busy, 1);
    in_data = 16'hA002;
    tick();
    chk("s1_w0_htrans", HTRANS, 2'b10);
    chk("s1_w0_haddr",  HADDR,  BASE);
    in_data = 16'hA003; in_eom = 1'b1;
    tick();
    in_valid = 1'b0; in_eom = 1'b0;
    chk("s1_w0_dph_htrans", HTRANS, 2'b00);
    chk("s1_w0_hwdata", HWDATA, 32'hA001A001);
    tick();
    chk("s1_w1_htrans", HTRANS, 2'b10);
    chk("s1_w1_haddr",  HADDR,  BASE + 32'd2);
    chk("s1_ptr1",      wr_ptr, 1);
    chk("s1_no_msg",    msg_done, 0);
    tick();
    chk("s1_w1_hwdata", HWDATA, 32'hA002A002);
    tick();
    chk("s1_w2_haddr",  HADDR,  BASE + 32'd4);
    chk("s1_ptr2",      wr_ptr, 2);
    tick();
    chk("s1_w2_hwdata", HWDATA, 32'hA003A003);
    tick();
    chk("s1_msg_done",  msg_done, 1);
    chk("s1_ptr3",      wr_ptr, 3);
    chk("s1_htrans_idle", HTRANS, 2'b00);
    tick();
    chk("s1_msg_pulse_end", msg_done, 0);
    chk("s1_busy_end", busy, 0);
    chk("s1_msg_count", n_msg - msg0, 1);

    // 2: two ADDR wait states and three DATA wait states
    base_idx = mon_addr.size();
    in_valid = 1'b1; in_data = 16'hB001; in_eom = 1'b1;
    tick();
    in_valid = 1'b0; in_eom = 1'b0;
    HREADY = 1'b0;
    tick();
    chk("s2_addr_htrans", HTRANS, 2'b10);
    chk("s2_addr_haddr",  HADDR,  BASE + 32'd6);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("s2_addr_hold_htrans", HTRANS, 2'b10);
      chk("s2_addr_hold_haddr",  HADDR,  BASE + 32'd6);
    end
    HREADY = 1'b1;
    tick();
    HREADY = 1'b0;
    chk("s2_dph_htrans", HTRANS, 2'b00);
    chk("s2_dph_hwdata", HWDATA, 32'hB001B001);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s2_dph_hold_hwdata", HWDATA, 32'hB001B001);
      chk("s2_dph_hold_htrans", HTRANS, 2'b00);
      chk("s2_dph_hold_ptr",    wr_ptr, 3);
    end
    HREADY = 1'b1;
    tick();
    chk("s2_ptr4", wr_ptr, 4);
    chk("s2_msg_done", msg_done, 1);
    drain();
    chk("s2_one_write", mon_addr.size() - base_idx, 1);
    chk("s2_mon_addr",  mon_addr[base_idx], BASE + 32'd6);

    // 3: five words across the ring wrap (slots 4,5,6,7,0)
    base_idx = mon_addr.size();
    for (int i = 0; i < 5; i++) push(16'hC001 + 16'(i), i == 4);
    drain();
    chk("s3_write_count", mon_addr.size() - base_idx, 5);
    for (int i = 0; i < 5; i++) begin
      chk("s3_addr", mon_addr[base_idx + i], BASE + 32'(2 * ((4 + i) % RW)));
      chk("s3_data", mon_data[base_idx + i], {16'hC001 + 16'(i), 16'hC001 + 16'(i)});
    end
    chk("s3_ptr_wrapped", wr_ptr, 1);

    // 4: slave stalls in DATA; FIFO fills, back-pressure, then release
    base_idx = mon_addr.size();
    push(16'hD001, 1'b0);
    tick();
    tick();
    HREADY = 1'b0;
    chk("s4_latched", HWDATA, 32'hD001D001);
    for (int i = 1; i < 5; i++) push(16'hD001 + 16'(i), 1'b0);
    chk("s4_full_ready", in_ready, 0);
    chk("s4_busy", busy, 1);
    in_valid = 1'b1; in_data = 16'hD006; in_eom = 1'b1;
    repeat (3) tick();
    chk("s4_still_blocked", in_ready, 0);
    chk("s4_hold_hwdata",   HWDATA, 32'hD001D001);
    chk("s4_hold_ptr",      wr_ptr, 1);
    HREADY = 1'b1;
    push(16'hD006, 1'b1);
    drain();
    chk("s4_write_count", mon_addr.size() - base_idx, 6);
    for (int i = 0; i < 6; i++) begin
      chk("s4_addr", mon_addr[base_idx + i], BASE + 32'(2 * (1 + i)));
      chk("s4_data", mon_data[base_idx + i], {16'hD001 + 16'(i), 16'hD001 + 16'(i)});
    end
    chk("s4_ptr", wr_ptr, 7);

    // 5: two-cycle ERROR on the second word (slot 7 then slot 0)
    err0 = n_err;
    push(16'hE001, 1'b0);
    push(16'hE002, 1'b1);
    tick();
    tick();
    chk("s5_w0_no_err", wr_err, 0);
    chk("s5_w0_ptr",    wr_ptr, 0);
    chk("s5_w1_haddr",  HADDR,  BASE);
    tick();
    chk("s5_w1_hwdata", HWDATA, 32'hE002E002);
    HREADY = 1'b0; HRESP = 2'b01;
    tick();
    chk("s5_err_wait_no_pulse", wr_err, 0);
    chk("s5_err_wait_ptr",      wr_ptr, 0);
    HREADY = 1'b1;
    tick();
    HRESP = 2'b00;
    chk("s5_wr_err",   wr_err,   1);
    chk("s5_msg_done", msg_done, 1);
    chk("s5_ptr_adv",  wr_ptr,   1);
`ifdef BC_RX_WR_ERR_CNT_EN
    chk("s5_err_cnt",  err_cnt,  1);
`endif
    tick();
    chk("s5_err_pulse_end", wr_err, 0);
    chk("s5_err_count", n_err - err0, 1);

    // 6: ptr_clr during DATA defers the clear to completion
    push(16'hF001, 1'b0);
    tick();
    tick();
    chk("s6_in_data_htrans", HTRANS, 2'b00);
    HREADY = 1'b0; ptr_clr = 1'b1;
    tick();
    ptr_clr = 1'b0;
    chk("s6_ptr_not_yet", wr_ptr, 1);
`ifdef BC_RX_WR_ERR_CNT_EN
    chk("s6_err_cnt_clr", err_cnt, 0);
`endif
    HREADY = 1'b1;
    tick();
    chk("s6_ptr_cleared", wr_ptr, 0);
    drain();
    push(16'hF002, 1'b1);
    tick();
    chk("s6_next_htrans", HTRANS, 2'b10);
    chk("s6_next_haddr",  HADDR,  BASE);
    drain();
    chk("s6_ptr_after", wr_ptr, 1);
    ptr_clr = 1'b1;
    tick();
    ptr_clr = 1'b0;
    chk("s6_idle_clr", wr_ptr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
